// File: rtl/arqui_merge_pkg.sv
// Shared constants, FSM encoding and the round-robin grant helper for the two-lane merge.
package arqui_merge_pkg;

  localparam int unsigned DEF_DATA_SIZE  = 6;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_ADDR_SIZE  = 2;
  localparam int unsigned DEF_AF_THRESH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  // Lone non-empty lane wins; with both non-empty, the lane not served last wins.
  function automatic logic pick_lane(input logic ne0, input logic ne1, input logic last_grant);
    logic lane;
    if (ne0 && ne1) begin
      lane = ~last_grant;
    end else begin
      lane = ne1;
    end
    return lane;
  endfunction

endpackage

// File: rtl/arqui_merge_if.sv
// Lane write strobes, merged output stream and status flags of the two-lane merge.
interface arqui_merge_if #(
  parameter int unsigned DATA_SIZE = arqui_merge_pkg::DEF_DATA_SIZE
) ();

  logic                 push0;
  logic [DATA_SIZE-1:0] data_in0;
  logic                 push1;
  logic [DATA_SIZE-1:0] data_in1;
  logic                 ready_out;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 lane_out;
  logic                 almost_full0;
  logic                 almost_full1;
  logic                 error_out;
  logic                 idle_out;

  modport master (
    output push0, data_in0, push1, data_in1, ready_out,
    input  data_out, valid_out, lane_out, almost_full0, almost_full1, error_out, idle_out
  );

  modport slave (
    input  push0, data_in0, push1, data_in1, ready_out,
    output data_out, valid_out, lane_out, almost_full0, almost_full1, error_out, idle_out
  );

endinterface

// File: rtl/arqui_merge_lane_fifo.sv
// Per-lane FIFO with combinational head word; a push on a full FIFO lands only if it is popped
// in the same cycle, otherwise the push is ignored and the caller flags the overflow.
module lane_fifo #(
  parameter int unsigned DATA_SIZE  = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_SIZE  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned CW = ADDR_SIZE + 1;

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 wr_en, rd_en;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign data_out = mem_q[rd_ptr_q];
  assign rd_en    = pop & ~empty;
  assign wr_en    = push & (~full | rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + ADDR_SIZE'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/arqui_merge.sv
// Merges two lane FIFOs round-robin onto one registered valid/ready stream; 2 edges push-to-valid.
// The output register holds while valid_out & !ready_out; almost_full flags throttle the lane sources.
module arqui_merge import arqui_merge_pkg::*; #(
  parameter int unsigned DATA_SIZE  = DEF_DATA_SIZE,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH
) (
  input logic          clk,
  input logic          reset,
  arqui_merge_if.slave bus
);

  localparam int unsigned CW = ADDR_SIZE + 1;

  logic [1:0]           push, pop, full, empty;
  logic [DATA_SIZE-1:0] head0, head1;
  logic [CW-1:0]        count0, count1;

  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 lane_q, lane_d;
  logic                 error_q, error_d;
  logic                 last_grant_q, last_grant_d;
  state_t               state_q, state_d;

  logic                 load_en, any_ne, grant, overflow, busy;

  assign push = {bus.push1, bus.push0};

  lane_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_lane0 (
    .clk     (clk),
    .reset   (reset),
    .push    (push[0]),
    .pop     (pop[0]),
    .data_in (bus.data_in0),
    .data_out(head0),
    .count   (count0),
    .full    (full[0]),
    .empty   (empty[0])
  );

  lane_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_lane1 (
    .clk     (clk),
    .reset   (reset),
    .push    (push[1]),
    .pop     (pop[1]),
    .data_in (bus.data_in1),
    .data_out(head1),
    .count   (count1),
    .full    (full[1]),
    .empty   (empty[1])
  );

  assign load_en = ~valid_q | bus.ready_out;
  assign any_ne  = ~(empty[0] & empty[1]);
  assign grant   = pick_lane(~empty[0], ~empty[1], last_grant_q);
  assign busy    = any_ne | valid_q;

  always_comb begin
    pop          = '0;
    data_out_d   = data_out_q;
    valid_d      = valid_q;
    lane_d       = lane_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (any_ne) begin
        pop[grant]   = 1'b1;
        data_out_d   = grant ? head1 : head0;
        lane_d       = grant;
        valid_d      = 1'b1;
        last_grant_d = grant;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // A full lane only overflows when its head is not leaving in the same cycle.
  assign overflow = |(push & full & ~pop);
  assign error_d  = error_q | overflow;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (busy)  state_d = ST_ACTIVE;
      ST_ACTIVE: if (!busy) state_d = ST_IDLE;
      default:   state_d = ST_ERROR;
    endcase
    if (overflow) begin
      state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      lane_q       <= 1'b0;
      error_q      <= 1'b0;
      last_grant_q <= 1'b1;
      state_q      <= ST_IDLE;
    end else begin
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      lane_q       <= lane_d;
      error_q      <= error_d;
      last_grant_q <= last_grant_d;
      state_q      <= state_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.lane_out     = lane_q;
  assign bus.error_out    = error_q;
  assign bus.almost_full0 = (count0 >= CW'(AF_THRESH));
  assign bus.almost_full1 = (count1 >= CW'(AF_THRESH));
  assign bus.idle_out     = empty[0] & empty[1] & ~valid_q;

endmodule
